// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and defaults for the rx (and future tx) path
package uart_pkg;

    localparam int UART_OVERSAMPLE = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE,
        WAIT_IDLE
    } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, baud clock and host read handshake of the UART receiver
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 baud_clk;
    logic                 rx;
    logic                 rd_en;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;
    logic                 busy;

    modport master (
        output baud_clk, rx, rd_en,
        input  data_out, data_valid, parity_err, frame_err, overrun_err, busy
    );

    modport slave (
        input  baud_clk, rx, rd_en,
        output data_out, data_valid, parity_err, frame_err, overrun_err, busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rx two-flop synchroniser and baud_clk rising-edge tick
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic baud_clk,
    input  logic rx,
    output logic rx_s,
    output logic tick
);
    logic rx_meta;
    logic baud_d;

    // Sync flops reset to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            baud_d  <= 1'b0;
            tick    <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            baud_d  <= baud_clk;
            tick    <= baud_clk & ~baud_d;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with held byte, read handshake and error flags
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);
    localparam int CW = $clog2(OVERSAMPLE) + 1;
    localparam int BW = $clog2(DATA_BITS) + 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic rx_s;
    logic tick;

    uart_rx_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .baud_clk (bus.baud_clk),
        .rx       (bus.rx),
        .rx_s     (rx_s),
        .tick     (tick)
    );

    uart_state_t          state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 perr, perr_n;
    logic                 ferr, ferr_n;

    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;
    logic                 perr_r;
    logic                 ferr_r;
    logic                 ovr_r;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            perr    <= perr_n;
            ferr    <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        perr_n  = perr;
        ferr_n  = ferr;
        case (state)
            IDLE: begin
                if (tick && !rx_s) begin
                    state_n = START;
                    cnt_n   = CW'(1);
                end
            end
            START: begin
                // Re-check the line half a bit after the edge to reject glitches.
                if (tick) begin
                    if (cnt == CNT_HALF) begin
                        cnt_n = '0;
                        bit_n = '0;
                        state_n = rx_s ? IDLE : DATA;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        shift_n = {rx_s, shift[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            bit_n   = '0;
                            perr_n  = 1'b0;
                            state_n = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_n = bit_cnt + BW'(1);
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        perr_n  = ((^shift) ^ rx_s) != (PARITY_ODD != 0);
                        state_n = STOP;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        ferr_n  = ~rx_s;
                        state_n = DONE;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            // A framing error usually means a break; wait for the line to recover.
            DONE:      state_n = ferr ? WAIT_IDLE : IDLE;
            WAIT_IDLE: if (rx_s) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_r  <= '0;
            valid_r <= 1'b0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
            ovr_r   <= 1'b0;
        end else if (state == DONE) begin
            data_r  <= shift;
            perr_r  <= perr & (PARITY_EN != 0);
            ferr_r  <= ferr;
            valid_r <= 1'b1;
            if (bus.rd_en && valid_r) begin
                ovr_r <= 1'b0;
            end else if (valid_r) begin
                ovr_r <= 1'b1;
            end
        end else if (bus.rd_en && valid_r) begin
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
        end
    end

    assign bus.data_out    = data_r;
    assign bus.data_valid  = valid_r;
    assign bus.parity_err  = perr_r;
    assign bus.frame_err   = ferr_r;
    assign bus.overrun_err = ovr_r;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (8N1 and 8E1 instances)
module tb_uart_rx;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic baud  = 1'b0;

    uart_rx_if #(.DATA_BITS(8)) ifa ();
    uart_rx_if #(.DATA_BITS(8)) ifb ();

    assign ifa.baud_clk = baud;
    assign ifb.baud_clk = baud;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    always #5 clk = ~clk;

    // baud_clk toggles every 4 clk, offset so its edges never coincide with clk edges
    initial begin
        #2;
        forever #40 baud = ~baud;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input int w, input logic v);
        if (w == 0) ifa.rx = v;
        else        ifb.rx = v;
    endtask

    task automatic hold_bits(input int n);
        repeat (n * 64) @(negedge clk);
    endtask

    task automatic send_frame(input int w, input logic [7:0] d, input bit par,
                              input logic pbit, input logic stopb);
        set_rx(w, 1'b0);
        hold_bits(1);
        for (int i = 0; i < 8; i++) begin
            set_rx(w, d[i]);
            hold_bits(1);
        end
        if (par) begin
            set_rx(w, pbit);
            hold_bits(1);
        end
        set_rx(w, stopb);
        hold_bits(1);
    endtask

    task automatic rd_pulse(input int w);
        if (w == 0) ifa.rd_en = 1'b1;
        else        ifb.rd_en = 1'b1;
        @(negedge clk);
        ifa.rd_en = 1'b0;
        ifb.rd_en = 1'b0;
        @(negedge clk);
    endtask

    logic       busy_seen;
    logic       prev_busy;
    int         n_fall;
    logic [7:0] rd;
    logic       rpbit;
    logic       rstop;
    logic       exp_valid;
    logic       exp_ovr;
    logic [7:0] exp_data;

    initial begin
        ifa.rx = 1'b1;  ifa.rd_en = 1'b0;
        ifb.rx = 1'b1;  ifb.rd_en = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("reset_a", {ifa.data_out, ifa.data_valid, ifa.parity_err, ifa.frame_err,
                             ifa.overrun_err, ifa.busy}, 32'h0);
        check_eq("reset_b", {ifb.data_out, ifb.data_valid, ifb.parity_err, ifb.frame_err,
                             ifb.overrun_err, ifb.busy}, 32'h0);
        reset = 1'b1;
        hold_bits(2);

        // 8N1 byte
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
        check_eq("t1_data", ifa.data_out, 8'hA5);
        check_eq("t1_valid", ifa.data_valid, 1);
        check_eq("t1_errs", {ifa.parity_err, ifa.frame_err, ifa.overrun_err}, 0);
        check_eq("t1_busy", ifa.busy, 0);
        rd_pulse(0);
        check_eq("t1_rd_clears", ifa.data_valid, 0);
        hold_bits(1);

        // two-tick glitch
        busy_seen = 1'b0;
        ifa.rx = 1'b0;
        repeat (16) begin @(negedge clk); busy_seen |= ifa.busy; end
        ifa.rx = 1'b1;
        repeat (96) begin @(negedge clk); busy_seen |= ifa.busy; end
        check_eq("t2_busy_pulse", busy_seen, 1);
        check_eq("t2_busy_end", ifa.busy, 0);
        check_eq("t2_no_valid", ifa.data_valid, 0);

        // framing error followed by a long break
        send_frame(0, 8'h3C, 0, 1'b0, 1'b0);
        check_eq("t3_data", ifa.data_out, 8'h3C);
        check_eq("t3_valid", ifa.data_valid, 1);
        check_eq("t3_ferr", ifa.frame_err, 1);
        rd_pulse(0);
        hold_bits(20);
        check_eq("t3_no_second", ifa.data_valid, 0);
        check_eq("t3_waiting", ifa.busy, 1);
        ifa.rx = 1'b1;
        hold_bits(1);
        check_eq("t3_idle", ifa.busy, 0);
        hold_bits(1);

        // even parity on 0x07 (three ones)
        send_frame(1, 8'h07, 1, 1'b1, 1'b1);
        check_eq("t4_data", ifb.data_out, 8'h07);
        check_eq("t4_perr_ok", ifb.parity_err, 0);
        rd_pulse(1);
        hold_bits(1);
        send_frame(1, 8'h07, 1, 1'b0, 1'b1);
        check_eq("t4_perr_bad", ifb.parity_err, 1);
        check_eq("t4_ferr", ifb.frame_err, 0);
        rd_pulse(1);
        hold_bits(1);

        // back-to-back overrun; remember where the second frame completes
        @(posedge baud); @(negedge clk);
        n_fall = -1;
        prev_busy = 1'b0;
        fork
            begin
                send_frame(0, 8'h11, 0, 1'b0, 1'b1);
                send_frame(0, 8'h22, 0, 1'b0, 1'b1);
            end
            begin
                for (int n = 0; n < 1400; n++) begin
                    @(negedge clk);
                    if (prev_busy && !ifa.busy) n_fall = n;
                    prev_busy = ifa.busy;
                end
            end
        join
        check_eq("t5_done_seen", n_fall > 600, 1);
        check_eq("t5_data", ifa.data_out, 8'h22);
        check_eq("t5_ovr", ifa.overrun_err, 1);
        rd_pulse(0);
        check_eq("t5_rd_clears", {ifa.data_valid, ifa.overrun_err}, 0);
        hold_bits(2);

        // same frames, same phase, read strobe in the completion cycle of the second byte
        @(posedge baud); @(negedge clk);
        fork
            begin
                send_frame(0, 8'h11, 0, 1'b0, 1'b1);
                send_frame(0, 8'h22, 0, 1'b0, 1'b1);
            end
            begin
                if (n_fall > 0) begin
                    repeat (n_fall) @(negedge clk);
                    ifa.rd_en = 1'b1;
                    @(negedge clk);
                    ifa.rd_en = 1'b0;
                end
            end
        join
        check_eq("t5b_data", ifa.data_out, 8'h22);
        check_eq("t5b_valid", ifa.data_valid, 1);
        check_eq("t5b_no_ovr", ifa.overrun_err, 0);
        hold_bits(1);

        // reset mid-frame
        fork
            send_frame(0, 8'hFF, 0, 1'b0, 1'b1);
            begin
                hold_bits(3);
                reset = 1'b0;
                repeat (3) @(negedge clk);
                check_eq("t6_reset_out", {ifa.data_valid, ifa.overrun_err, ifa.busy}, 0);
                reset = 1'b1;
            end
        join
        hold_bits(1);
        check_eq("t6_abandoned", ifa.data_valid, 0);
        send_frame(0, 8'h5A, 0, 1'b0, 1'b1);
        check_eq("t6_data", ifa.data_out, 8'h5A);
        check_eq("t6_errs", {ifa.data_valid, ifa.parity_err, ifa.frame_err, ifa.overrun_err}, 4'b1000);
        rd_pulse(0);
        hold_bits(1);

        // random 8E1 frames: reference decides parity/frame status from bit counts
        for (int k = 0; k < 14; k++) begin
            rd    = 8'($urandom);
            rpbit = 1'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            send_frame(1, rd, 1, rpbit, rstop);
            check_eq("rnd_b_data", ifb.data_out, rd);
            check_eq("rnd_b_perr", ifb.parity_err, ($countones({rd, rpbit}) % 2) != 0);
            check_eq("rnd_b_ferr", ifb.frame_err, !rstop);
            rd_pulse(1);
            ifb.rx = 1'b1;
            hold_bits($urandom_range(1, 2));
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end

        // random 8N1 frames with random reads: track valid/overrun in the reference
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        for (int k = 0; k < 14; k++) begin
            rd = 8'($urandom);
            send_frame(0, rd, 0, 1'b0, 1'b1);
            exp_data = rd;
            if (exp_valid) exp_ovr = 1'b1;
            exp_valid = 1'b1;
            check_eq("rnd_a_data", ifa.data_out, exp_data);
            check_eq("rnd_a_flags", {ifa.data_valid, ifa.overrun_err, ifa.frame_err},
                     {exp_valid, exp_ovr, 1'b0});
            if ($urandom_range(0, 1) != 0) begin
                rd_pulse(0);
                exp_valid = 1'b0;
                exp_ovr   = 1'b0;
                check_eq("rnd_a_read", {ifa.data_valid, ifa.overrun_err}, 0);
            end
            hold_bits(1);
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
